// File: rtl/board_io_ctrl.sv
// Front-panel controller: synchronises and debounces switches and keys, counts key events,
// and drives the LED bank and seven-segment digits.
module board_io_ctrl #(
    parameter int NUM_SW     = 10,
    parameter int NUM_KEY    = 4,
    parameter int DEB_CYCLES = 240000,
    parameter int DEB_W      = 18,
    parameter int HB_W       = 25,
    parameter int NUM_DIGITS = 4,
    parameter int LEDG_W     = 8
) (
    input  logic                    sysclk,
    input  logic                    reset_switch,
    input  logic [NUM_SW-1:0]       sw_i,
    input  logic [NUM_KEY-1:0]      key_n_i,
    input  logic [4*NUM_DIGITS-1:0] ext_value_i,
    output logic [NUM_SW-1:0]       sw_db_o,
    output logic [NUM_KEY-1:0]      key_press_o,
    output logic                    heartbeat_o,
    output logic [4*NUM_DIGITS-1:0] event_cnt_o,
    output logic [LEDG_W-1:0]       ledg_o,
    output logic [7*NUM_DIGITS-1:0] hex_o
);
    localparam int NUM_CH = NUM_SW + NUM_KEY;
    localparam int VAL_W  = 4 * NUM_DIGITS;
    localparam int HEX_W  = 7 * NUM_DIGITS;
    // Keys are active-low, so their channels idle (and reset) at 1; switches idle at 0.
    localparam logic [NUM_CH-1:0] CH_RST   = {{NUM_KEY{1'b1}}, {NUM_SW{1'b0}}};
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [NUM_CH-1:0]  w_raw;
    logic [NUM_CH-1:0]  r_sync1;
    logic [NUM_CH-1:0]  r_sync2;
    logic [NUM_CH-1:0]  r_stable;
    logic [DEB_W-1:0]   r_cnt [NUM_CH];
    logic [NUM_KEY-1:0] w_key_stable;
    logic [NUM_KEY-1:0] r_key_prev;
    logic [NUM_KEY-1:0] r_key_press;
    logic [VAL_W-1:0]   r_event;
    logic [HB_W-1:0]    r_hb;
    logic [LEDG_W-1:0]  r_ledg;
    logic [HEX_W-1:0]   r_hex;
    logic [1:0]         w_mode;
    logic [VAL_W-1:0]   w_src;
    logic [HEX_W-1:0]   w_enc;
    logic [HEX_W-1:0]   w_hex_next;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    assign w_raw = {key_n_i, sw_i};

    // A change is accepted only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge sysclk or posedge reset_switch) begin
        if (reset_switch) begin
            r_sync1  <= CH_RST;
            r_sync2  <= CH_RST;
            r_stable <= CH_RST;
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DEB_LAST) begin
                    r_stable[i] <= r_sync2[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    assign w_key_stable = r_stable[NUM_CH-1:NUM_SW];

    always_ff @(posedge sysclk or posedge reset_switch) begin
        if (reset_switch) begin
            r_key_prev  <= '1;
            r_key_press <= '0;
        end else begin
            r_key_prev  <= w_key_stable;
            r_key_press <= r_key_prev & ~w_key_stable;
        end
    end

    // Clear wins; simultaneous increment and decrement cancel out.
    always_ff @(posedge sysclk or posedge reset_switch) begin
        if (reset_switch) begin
            r_event <= '0;
        end else if (r_key_press[3]) begin
            r_event <= '0;
        end else if (r_key_press[1] && !r_key_press[2]) begin
            r_event <= r_event + VAL_W'(1);
        end else if (r_key_press[2] && !r_key_press[1]) begin
            r_event <= r_event - VAL_W'(1);
        end
    end

    always_ff @(posedge sysclk or posedge reset_switch) begin
        if (reset_switch) begin
            r_hb   <= '0;
            r_ledg <= '0;
        end else begin
            r_hb   <= r_hb + HB_W'(1);
            r_ledg <= {r_hb[HB_W-1], r_stable[LEDG_W-2:0]};
        end
    end

    assign w_mode = r_stable[9:8];
    assign w_src  = (w_mode == 2'b01) ? r_event : ext_value_i;

    always_comb begin
        w_enc      = '1;
        w_hex_next = '1;
        for (int d = 0; d < NUM_DIGITS; d++) w_enc[7*d +: 7] = seg7(w_src[4*d +: 4]);
        case (w_mode)
            2'b00:   w_hex_next = '1;
            2'b11:   w_hex_next = '0;
            default: w_hex_next = w_enc;
        endcase
    end

    always_ff @(posedge sysclk or posedge reset_switch) begin
        if (reset_switch) r_hex <= '1;
        else              r_hex <= w_hex_next;
    end

    assign sw_db_o     = r_stable[NUM_SW-1:0];
    assign key_press_o = r_key_press;
    assign heartbeat_o = r_hb[HB_W-1];
    assign event_cnt_o = r_event;
    assign ledg_o      = r_ledg;
    assign hex_o       = r_hex;
endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed plus randomized bench for board_io_ctrl with short debounce and heartbeat
// periods; expected values come from a small behavioural model of the panel.
module tb_board_io_ctrl;
    localparam int DEB = 4;

    logic        sysclk = 1'b0;
    logic        reset_switch;
    logic [9:0]  sw_i;
    logic [3:0]  key_n_i;
    logic [15:0] ext_value_i;
    logic [9:0]  sw_db_o;
    logic [3:0]  key_press_o;
    logic        heartbeat_o;
    logic [15:0] event_cnt_o;
    logic [7:0]  ledg_o;
    logic [27:0] hex_o;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [15:0] m_cnt;
    logic [15:0] prev_ext;
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    board_io_ctrl #(
        .NUM_SW(10), .NUM_KEY(4), .DEB_CYCLES(DEB), .DEB_W(18), .HB_W(4),
        .NUM_DIGITS(4), .LEDG_W(8)
    ) dut (
        .sysclk(sysclk), .reset_switch(reset_switch), .sw_i(sw_i), .key_n_i(key_n_i),
        .ext_value_i(ext_value_i), .sw_db_o(sw_db_o), .key_press_o(key_press_o),
        .heartbeat_o(heartbeat_o), .event_cnt_o(event_cnt_o), .ledg_o(ledg_o), .hex_o(hex_o)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [27:0] hex_of(input logic [15:0] v);
        logic [27:0] r;
        for (int d = 0; d < 4; d++) r[7*d +: 7] = seg_tab[v[4*d +: 4]];
        return r;
    endfunction

    // Heartbeat is the bit-3 of a 4-bit count of cycles since reset release.
    task automatic tick();
        @(posedge sysclk);
        #1;
        cyc++;
        check("heartbeat", 32'(heartbeat_o), 32'(((cyc % 16) >= 8)));
        check("ledg7", 32'(ledg_o[7]), 32'((((cyc - 1) % 16) >= 8)));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sw_db"}, 32'(sw_db_o), 32'(0));
        check({tag, "_key_press"}, 32'(key_press_o), 32'(0));
        check({tag, "_heartbeat"}, 32'(heartbeat_o), 32'(0));
        check({tag, "_event"}, 32'(event_cnt_o), 32'(0));
        check({tag, "_ledg"}, 32'(ledg_o), 32'(0));
        check({tag, "_hex"}, 32'(hex_o), 32'h0FFFFFFF);
    endtask

    task automatic release_reset();
        @(posedge sysclk);
        @(posedge sysclk);
        #1;
        reset_switch = 1'b0;
        cyc = 0;
    endtask

    function automatic logic [15:0] apply_keys(input logic [15:0] v, input logic [3:0] mask);
        if (mask[3]) return 16'h0;
        if (mask[1] && !mask[2]) return v + 16'd1;
        if (mask[2] && !mask[1]) return v - 16'd1;
        return v;
    endfunction

    // Hold the keys in mask down, release, and expect exactly one pulse 2+DEB+1 cycles in.
    task automatic press(input string tag, input logic [3:0] mask, input int hold);
        int pulses = 0;
        int busy = 0;
        int first_at = -1;
        key_n_i = key_n_i & ~mask;
        for (int i = 1; i <= hold + 12; i++) begin
            if (i == hold + 1) key_n_i = key_n_i | mask;
            tick();
            if (key_press_o != 4'h0) begin
                busy++;
                if (key_press_o == mask) begin
                    pulses++;
                    if (first_at < 0) first_at = i;
                end
            end
        end
        check({tag, "_pulses"}, 32'(pulses), 32'(1));
        check({tag, "_busy"}, 32'(busy), 32'(1));
        check({tag, "_pulse_at"}, 32'(first_at), 32'(2 + DEB + 1));
        m_cnt = apply_keys(m_cnt, mask);
        check({tag, "_event"}, 32'(event_cnt_o), 32'(m_cnt));
    endtask

    initial begin
        reset_switch = 1'b1;
        sw_i = '0;
        key_n_i = '1;
        ext_value_i = '0;
        m_cnt = '0;
        #1;
        check_reset_state("rst0");
        release_reset();
        repeat (20) tick();

        // Switch 0 accepted exactly 2+DEB cycles after the edge, LED one cycle later.
        sw_i[0] = 1'b1;
        repeat (5) tick();
        check("sw0_early", 32'(sw_db_o[0]), 32'(0));
        tick();
        check("sw0_rise", 32'(sw_db_o[0]), 32'(1));
        check("ledg0_lag", 32'(ledg_o[0]), 32'(0));
        tick();
        check("ledg0_rise", 32'(ledg_o[0]), 32'(1));
        sw_i[1] = 1'b1;
        repeat (3) tick();
        sw_i[1] = 1'b0;
        repeat (10) tick();
        check("glitch_sw_db", 32'(sw_db_o), 32'h001);

        sw_i[9:8] = 2'b01;
        repeat (8) tick();
        check("mode01_zero", 32'(hex_o), 32'(hex_of(16'h0)));
        for (int n = 0; n < 3; n++) press("key1_triple", 4'b0010, 10);
        check("cnt3_value", 32'(event_cnt_o), 32'(3));
        check("cnt3_hex", 32'(hex_o), 32'({7'h40, 7'h40, 7'h40, 7'h30}));

        // Asynchronous reset in the middle of a cycle while all keys are mid-debounce.
        key_n_i = 4'b0000;
        repeat (3) tick();
        #2;
        reset_switch = 1'b1;
        #1;
        check_reset_state("rst_mid");
        key_n_i = '1;
        m_cnt = '0;
        release_reset();
        repeat (10) tick();
        check("post_rst_sw_db", 32'(sw_db_o), 32'h101);

        press("dec_wrap", 4'b0100, 10);
        check("dec_wrap_hex", 32'(hex_o), 32'({4{7'h0E}}));
        press("dec2", 4'b0100, 9);
        press("clr_over_inc", 4'b1010, 10);
        press("inc", 4'b0010, 8);
        press("inc_dec_hold", 4'b0110, 11);
        press("key0_only", 4'b0001, 10);
        check("after_key0_hex", 32'(hex_o), 32'(hex_of(m_cnt)));

        for (int n = 0; n < 12; n++) begin
            press("rand_keys", 4'($urandom_range(1, 15)), int'($urandom_range(8, 14)));
            check("rand_keys_hex", 32'(hex_o), 32'(hex_of(m_cnt)));
        end

        for (int n = 0; n < 4; n++) begin
            sw_i[7:0] = 8'($urandom);
            repeat (8) tick();
            check("rand_sw_db", 32'(sw_db_o), 32'({2'b01, sw_i[7:0]}));
            check("rand_ledg", 32'(ledg_o[6:0]), 32'(sw_i[6:0]));
        end

        ext_value_i = 16'h1234;
        sw_i[9:8] = 2'b10;
        repeat (8) tick();
        check("mode10_1234", 32'(hex_o), 32'({7'h79, 7'h24, 7'h30, 7'h19}));
        prev_ext = ext_value_i;
        for (int n = 0; n < 8; n++) begin
            ext_value_i = 16'($urandom);
            #1;
            check("ext_reg_hold", 32'(hex_o), 32'(hex_of(prev_ext)));
            tick();
            check("ext_reg_next", 32'(hex_o), 32'(hex_of(ext_value_i)));
            prev_ext = ext_value_i;
        end
        sw_i[9:8] = 2'b11;
        repeat (8) tick();
        check("mode11_lamp", 32'(hex_o), 32'(0));
        sw_i[9:8] = 2'b00;
        repeat (8) tick();
        check("mode00_blank", 32'(hex_o), 32'h0FFFFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
